// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FSM state type, default sizes and index-width helper for the FFT scheduler.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_LOG_N  = 6;
  localparam int DEF_BF_LAT = 3;

  // Width needed to index n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_bf_delay.sv
// rtl/fft_bf_delay.sv - fixed-depth valid+data shift register, cleared by reset.
module fft_bf_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     dat_q [DEPTH];
  logic [W-1:0]     dat_d [DEPTH];

  always_comb begin
    vld_d[0] = in_valid;
    dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/fft_bf_sched.sv
// rtl/fft_bf_sched.sv - in-place radix-2 DIT FFT butterfly scheduler with drain gaps between stages.
// Optional FFT_BF_SCHED_SCALE_EN adds a per-stage scale-by-half request (scale, scale_mask).
module fft_bf_sched
  import fft_pkg::*;
#(
  parameter int LOG_N  = DEF_LOG_N,
  parameter int BF_LAT = DEF_BF_LAT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [idx_w(LOG_N)-1:0]    stage,
  output logic                       rd_en,
  output logic [LOG_N-1:0]           rd_addr0,
  output logic [LOG_N-1:0]           rd_addr1,
  output logic [LOG_N-2:0]           tw_addr,
  output logic                       wr_en,
  output logic [LOG_N-1:0]           wr_addr0,
  output logic [LOG_N-1:0]           wr_addr1
`ifdef FFT_BF_SCHED_SCALE_EN
  ,
  output logic                       scale,
  input  logic [LOG_N-1:0]           scale_mask
`endif
);

  localparam int AW = LOG_N;
  localparam int KW = LOG_N - 1;
  localparam int SW = idx_w(LOG_N);
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    dcnt_q, dcnt_d;

  logic [AW-1:0] k_ext, mask, pos, grp, a0, a1, tw_full;
  logic          issue;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          dcnt_d  = 4'(BF_LAT);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        // Leave only once the stage's last write-back has left the pipeline.
        if (dcnt_q == 4'd1) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // x0 has bit s clear; the group index fills the bits above s, the position the bits below.
  always_comb begin
    k_ext   = AW'(k_q);
    mask    = (AW'(1) << s_q) - AW'(1);
    pos     = k_ext & mask;
    grp     = k_ext >> s_q;
    a0      = ((grp << s_q) << 1) | pos;
    a1      = a0 | (AW'(1) << s_q);
    tw_full = pos << (LOG_N - 1 - int'(s_q));
  end

  assign issue    = (state_q == RUN);
  assign rd_en    = issue;
  assign rd_addr0 = issue ? a0 : '0;
  assign rd_addr1 = issue ? a1 : '0;
  assign tw_addr  = issue ? tw_full[AW-2:0] : '0;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign stage    = s_q;

`ifdef FFT_BF_SCHED_SCALE_EN
  assign scale = issue & scale_mask[s_q];
`endif

  fft_bf_delay #(
    .DEPTH (BF_LAT),
    .W     (2 * AW)
  ) u_wr_dly (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (issue),
    .in_data   ({rd_addr0, rd_addr1}),
    .out_valid (wr_en),
    .out_data  ({wr_addr0, wr_addr1})
  );

endmodule

// File: tb/tb_fft_bf_sched.sv
// tb/tb_fft_bf_sched.sv - self-checking bench: two scheduler instances against a cycle model.
module tb_fft_bf_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, start_a, start_b;

  logic       busy_a, done_a, rd_en_a, wr_en_a;
  logic [1:0] stage_a, tw_a;
  logic [2:0] ra0_a, ra1_a, wa0_a, wa1_a;

  logic       busy_b, done_b, rd_en_b, wr_en_b;
  logic [2:0] stage_b;
  logic [4:0] tw_b;
  logic [5:0] ra0_b, ra1_b, wa0_b, wa1_b;

`ifdef FFT_BF_SCHED_SCALE_EN
  logic       scale_a, scale_b;
  logic [2:0] mask_a = 3'b101;
  logic [5:0] mask_b = 6'b010011;
`endif

  fft_bf_sched #(.LOG_N(3), .BF_LAT(2)) dut_a (
    .clock(clk), .reset(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .stage(stage_a), .rd_en(rd_en_a), .rd_addr0(ra0_a), .rd_addr1(ra1_a),
    .tw_addr(tw_a), .wr_en(wr_en_a), .wr_addr0(wa0_a), .wr_addr1(wa1_a)
`ifdef FFT_BF_SCHED_SCALE_EN
    , .scale(scale_a), .scale_mask(mask_a)
`endif
  );

  fft_bf_sched #(.LOG_N(6), .BF_LAT(1)) dut_b (
    .clock(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .stage(stage_b), .rd_en(rd_en_b), .rd_addr0(ra0_b), .rd_addr1(ra1_b),
    .tw_addr(tw_b), .wr_en(wr_en_b), .wr_addr0(wa0_b), .wr_addr1(wa1_b)
`ifdef FFT_BF_SCHED_SCALE_EN
    , .scale(scale_b), .scale_mask(mask_b)
`endif
  );

  localparam int LAST_A = 3 * (4 + 2);
  localparam int LAST_B = 6 * (32 + 1);

  int checks = 0;
  int errors = 0;
  bit armed  = 0;
  int rt_a = -1, rt_b = -1;
  int last_wr_a = -1, last_wr_b = -1, done_t_a = -1, done_t_b = -1;
  int ndone_a = 0, ndone_b = 0, wr_cnt_a = 0;
  int pend_a [8];
  int pend_b [64];

  typedef struct {
    bit rd; int a0; int a1; int tw; int st;
    bit wr; int w0; int w1; bit busy; bit done;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // k-th address (ascending) whose bit s is clear is x0; partner is x0+span.
  function automatic void pair_of(input int logn, input int s, input int k,
                                  output int a0, output int a1, output int tw);
    int n, span, cnt;
    bit found;
    n = 1 << logn; span = 1 << s; cnt = 0; found = 0; a0 = 0;
    for (int a = 0; a < n; a++) begin
      if (!found && ((a / span) % 2) == 0) begin
        if (cnt == k) begin a0 = a; found = 1; end
        cnt++;
      end
    end
    a1 = a0 + span;
    tw = (a0 % span) * ((n / 2) / span);
  endfunction

  function automatic bit issue_at(input int logn, input int lat, input int t,
                                  output int s, output int k);
    int p;
    p = (1 << (logn - 1)) + lat;
    s = 0; k = 0;
    if (t < 1 || t > logn * p) return 0;
    s = (t - 1) / p;
    k = (t - 1) % p;
    return k < (1 << (logn - 1));
  endfunction

  function automatic exp_t model(input int logn, input int lat, input int t);
    exp_t e;
    int s, k, s2, k2, d, last;
    e = '{default: 0};
    if (t < 1) return e;
    last   = logn * ((1 << (logn - 1)) + lat);
    e.busy = (t <= last + 1);
    e.done = (t == last + 1);
    if (issue_at(logn, lat, t, s, k)) begin
      e.rd = 1; e.st = s;
      pair_of(logn, s, k, e.a0, e.a1, e.tw);
    end
    if (issue_at(logn, lat, t - lat, s2, k2)) begin
      e.wr = 1;
      pair_of(logn, s2, k2, e.w0, e.w1, d);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst_a) rt_a <= -1;
    else if (rt_a == -1) begin if (start_a) rt_a <= 1; end
    else if (rt_a >= LAST_A + 1) rt_a <= -1;
    else rt_a <= rt_a + 1;
    if (rst_b) rt_b <= -1;
    else if (rt_b == -1) begin if (start_b) rt_b <= 1; end
    else if (rt_b >= LAST_B + 1) rt_b <= -1;
    else rt_b <= rt_b + 1;
  end

  always @(negedge clk) begin
    exp_t ea, eb;
    if (armed) begin
      ea = model(3, 2, rt_a);
      chk("a_rd_en", 32'(rd_en_a), 32'(ea.rd));
      chk("a_wr_en", 32'(wr_en_a), 32'(ea.wr));
      chk("a_busy", 32'(busy_a), 32'(ea.busy));
      chk("a_done", 32'(done_a), 32'(ea.done));
      if (ea.rd) begin
        chk("a_rd_addr0", 32'(ra0_a), ea.a0);
        chk("a_rd_addr1", 32'(ra1_a), ea.a1);
        chk("a_tw_addr", 32'(tw_a), ea.tw);
        chk("a_stage", 32'(stage_a), ea.st);
      end
      if (ea.wr) begin
        chk("a_wr_addr0", 32'(wa0_a), ea.w0);
        chk("a_wr_addr1", 32'(wa1_a), ea.w1);
      end
`ifdef FFT_BF_SCHED_SCALE_EN
      chk("a_scale", 32'(scale_a), ea.rd ? 32'(mask_a[ea.st]) : 32'd0);
`endif
      if (rd_en_a) begin
        chk("a_hazard_x0", pend_a[ra0_a], 0);
        chk("a_hazard_x1", pend_a[ra1_a], 0);
        pend_a[ra0_a]++; pend_a[ra1_a]++;
      end
      if (wr_en_a) begin
        pend_a[wa0_a]--; pend_a[wa1_a]--;
        last_wr_a = rt_a; wr_cnt_a++;
      end
      if (done_a) begin done_t_a = rt_a; ndone_a++; end
      if (rst_a) foreach (pend_a[i]) pend_a[i] = 0;

      eb = model(6, 1, rt_b);
      chk("b_rd_en", 32'(rd_en_b), 32'(eb.rd));
      chk("b_wr_en", 32'(wr_en_b), 32'(eb.wr));
      chk("b_busy", 32'(busy_b), 32'(eb.busy));
      chk("b_done", 32'(done_b), 32'(eb.done));
      if (eb.rd) begin
        chk("b_rd_addr0", 32'(ra0_b), eb.a0);
        chk("b_rd_addr1", 32'(ra1_b), eb.a1);
        chk("b_tw_addr", 32'(tw_b), eb.tw);
        chk("b_stage", 32'(stage_b), eb.st);
      end
      if (eb.wr) begin
        chk("b_wr_addr0", 32'(wa0_b), eb.w0);
        chk("b_wr_addr1", 32'(wa1_b), eb.w1);
      end
`ifdef FFT_BF_SCHED_SCALE_EN
      chk("b_scale", 32'(scale_b), eb.rd ? 32'(mask_b[eb.st]) : 32'd0);
`endif
      if (rd_en_b) begin
        chk("b_hazard_x0", pend_b[ra0_b], 0);
        chk("b_hazard_x1", pend_b[ra1_b], 0);
        pend_b[ra0_b]++; pend_b[ra1_b]++;
      end
      if (wr_en_b) begin
        pend_b[wa0_b]--; pend_b[wa1_b]--;
        last_wr_b = rt_b;
      end
      if (done_b) begin done_t_b = rt_b; ndone_b++; end
      if (rst_b) foreach (pend_b[i]) pend_b[i] = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 0);
    chk({tag, "_rd_en"}, 32'(rd_en_a), 0);
    chk({tag, "_wr_en"}, 32'(wr_en_a), 0);
    chk({tag, "_done"}, 32'(done_a), 0);
    chk({tag, "_stage"}, 32'(stage_a), 0);
    chk({tag, "_addrs"}, {20'd0, ra0_a, ra1_a, wa0_a, wa1_a}, 0);
    chk({tag, "_tw"}, 32'(tw_a), 0);
  endtask

  initial begin
    exp_t m;
    rst_a = 1; rst_b = 1; start_a = 0; start_b = 0;
    foreach (pend_a[i]) pend_a[i] = 0;
    foreach (pend_b[i]) pend_b[i] = 0;
    repeat (2) step();
    rst_a = 0; rst_b = 0; armed = 1;
    @(negedge clk); #1;
    chk_a_zero("reset");
    chk("reset_b_busy", 32'(busy_b), 0);

    // Hand-computed pins on the model itself.
    m = model(3, 2, 8);
    chk("pin_s1k1", {m.a0[7:0], m.a1[7:0], m.tw[7:0], m.st[7:0]}, {8'd1, 8'd3, 8'd2, 8'd1});
    m = model(3, 2, 16);
    chk("pin_s2k3", {m.a0[7:0], m.a1[7:0], m.tw[7:0], m.st[7:0]}, {8'd3, 8'd7, 8'd3, 8'd2});
    m = model(3, 2, 18);
    chk("pin_lastwr", {31'd0, m.wr}, 1);
    m = model(6, 1, 199);
    chk("pin_b_done", {30'd0, m.wr, m.done}, 1);

    // Single transform on both instances.
    step();
    start_a = 1; start_b = 1;
    step();
    start_a = 0; start_b = 0;
    repeat (205) step();
    chk("a_last_wr_cycle", last_wr_a, 18);
    chk("a_done_cycle", done_t_a, 19);
    chk("a_done_count", ndone_a, 1);
    chk("b_last_wr_cycle", last_wr_b, 198);
    chk("b_done_cycle", done_t_b, 199);
    chk("b_done_count", ndone_b, 1);

    // start held high across a whole run: back-to-back transforms only.
    ndone_a = 0;
    start_a = 1;
    repeat (25) step();
    start_a = 0;
    repeat (30) step();
    chk("held_start_done_count", ndone_a, 2);

    // Reset in cycle 7 of a run aborts it with no trailing write-backs.
    start_a = 1;
    step();
    start_a = 0;
    repeat (6) step();
    rst_a = 1;
    step();
    rst_a = 0;
    @(negedge clk); #1;
    chk_a_zero("abort");
    wr_cnt_a = 0;
    repeat (20) step();
    chk("abort_no_writes", wr_cnt_a, 0);

    // Fresh run after abort.
    ndone_a = 0;
    start_a = 1;
    step();
    start_a = 0;
    repeat (22) step();
    chk("rerun_done_count", ndone_a, 1);
    chk("rerun_write_count", wr_cnt_a, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bf_sched.md
# fft_bf_sched

In-place radix-2 DIT FFT scheduler that sequences the shared Butterfly datapath over all stages of an N = 2^LOG_N point transform. It walks stage and butterfly counters, issues per-cycle read addresses, twiddle indices and delayed write-back addresses for a single-port-pair working memory, and inserts drain cycles so that no stage reads data before the previous stage has finished writing it. Sits between the OFDM receiver's symbol buffer (loaded in bit-reversed order upstream) and the butterfly/twiddle-multiply pipeline.

## Interface
- LOG_N, 6, log2 of transform size (N = 64); legal range 2..12
- BF_LAT, 3, cycles from read issue to write-back of that butterfly's results (memory read + twiddle multiply + butterfly); legal range 1..15
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a transform; honoured only when busy=0
- busy  out  1  high from the cycle after an accepted start up to and including the done cycle
- done  out  1  one-cycle pulse after the final write-back
- stage  out  $clog2(LOG_N)  current stage index s
- rd_en  out  1  butterfly issue strobe
- rd_addr0, rd_addr1  out  LOG_N  memory addresses of the butterfly's x0 and x1
- tw_addr  out  LOG_N-1  twiddle ROM index applied to x1
- wr_en  out  1  rd_en delayed BF_LAT cycles
- wr_addr0, wr_addr1  out  LOG_N  rd_addr0/rd_addr1 delayed BF_LAT cycles
- scale  out  1  (only with FFT_BF_SCHED_SCALE_EN) scale-by-half request to the butterfly, aligned with rd_en
- scale_mask  in  LOG_N  (only with FFT_BF_SCHED_SCALE_EN) bit s enables scaling in stage s

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN, s=0, k=0. start while busy ignored.
- RUN: rd_en=1 each cycle; butterfly k (0..N/2-1) of stage s, span = 2^s, pos = k & (span-1), grp = k >> s:
  - rd_addr0 = (grp << (s+1)) | pos; rd_addr1 = rd_addr0 + span
  - tw_addr = pos << (LOG_N-1-s)
  - k = N/2-1 -> DRAIN, drain counter = BF_LAT.
- DRAIN: rd_en=0 for exactly BF_LAT cycles; then s<LOG_N-1 -> RUN with s+1, k=0; else -> DONE.
- DONE: done=1 for one cycle, -> IDLE.
- Write pipeline: BF_LAT-deep shift register of {rd_en, rd_addr0, rd_addr1}; runs independently of the state and drives wr_*.
- All counters unsigned, widths as ports; no wrap beyond N/2-1 or LOG_N-1.

## Timing
- Reset: every output 0, state IDLE, counters 0, write pipeline flushed. Reset mid-transform aborts it; no pending writes emitted afterwards.
- start sampled at cycle 0 -> busy=1 and first rd_en at cycle 1.
- Per stage: N/2 issue cycles + BF_LAT drain cycles.
- Last wr_en at cycle LOG_N*(N/2+BF_LAT); done at that cycle +1; busy falls the cycle after done.
- Stage s+1 first read is exactly one cycle after stage s last write (no read-before-write hazard, no overlap).
- start asserted in the done cycle is ignored; a start one cycle later is accepted.
- stage output changes the cycle RUN is re-entered, not during DRAIN.

## Configuration
- FFT_BF_SCHED_SCALE_EN defined: scale and scale_mask ports exist; scale = rd_en & scale_mask[s], registered alongside rd_addr*.
- Undefined: ports absent; butterfly runs unscaled (bit growth handled by downstream width).

## Structure
- Shared package fft_pkg: state enum (IDLE/RUN/DRAIN/DONE), default LOG_N/BF_LAT constants, address-width helper.
- One sub-module: fft_bf_delay (parameterised-depth valid+data shift register) used for the write-address pipeline; address generation and FSM stay in fft_bf_sched.

## Test plan
- LOG_N=3, BF_LAT=2, start pulse: stage 0 pairs (0,1),(2,3),(4,5),(6,7) tw 0; stage 1 (0,2,tw0),(1,3,tw2),(4,6,tw0),(5,7,tw2); stage 2 (0,4,0),(1,5,1),(2,6,2),(3,7,3).
- Same config: wr_en/wr_addr equal rd_* shifted 2 cycles; last wr_en cycle 18, done cycle 19 only, busy low cycle 20.
- start held high throughout and re-pulsed mid-run: exactly one transform, then second starts the cycle after DONE→IDLE.
- reset at cycle 7 of a run: all outputs 0 next cycle, no wr_en thereafter until new start.
- BF_LAT=1, LOG_N=6: 6*(32+1)=198 cycles to last write; no read of stage s+1 before last write of stage s (scoreboard check).
- FFT_BF_SCHED_SCALE_EN, scale_mask=3'b101: scale high on all stage 0 and 2 issues, low on stage 1.
